if_prefetch_stage: RTL and testbench

Parametrised instruction-fetch stage with a small prefetch queue between a synchronous instruction ROM and the decode stage. It keeps fetching ahead while decode is stalled, up to the queue depth. It exposes a valid/ready handshake to decode and supports single-cycle redirect (branch/jump/exception) with a full flush of queued and in-flight fetches. It replaces the fixed 32-bit stall/branch fetch stage at the front of the MIPS pipeline.

---
 rtl/if_prefetch_stage_pkg.sv | 10 +
 rtl/if_pq_fifo.sv | 61 ++++++
 rtl/if_prefetch_stage.sv | 107 ++++++++++
 tb/tb_if_prefetch_stage.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants for the prefetching instruction-fetch stage.
// Optional perf counters in the stage are enabled by IF_PERF_EN.
package if_prefetch_stage_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/if_pq_fifo.sv
// Prefetch queue: DEPTH x WIDTH synchronous FIFO with flush.
// Flush and reset dominate push and pop in the same cycle.
module if_pq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             clr;

  assign clr     = reset || flush;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full queue needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with prefetch queue, redirect flush, sync ROM.
// Define IF_PERF_EN to add fetch/bubble performance counters.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              IMEM_AW  = 10,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              PQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_instr
`ifdef IF_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(PQ_DEPTH + 1);
  localparam int OW = CW + 1;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(PC_INC);
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

  logic [XLEN-1:0]   fetch_pc;
  logic              inflight;
  logic [XLEN-1:0]   inflight_pc;
  logic [CW-1:0]     count;
  logic [OW-1:0]     occ;
  logic              issue;
  logic              resp_push;
  logic              pop;
  logic [2*XLEN-1:0] head;

  // Slots already promised: queued entries plus the word on its way.
  assign occ   = {1'b0, count} + OW'(inflight);
  assign issue = !reset && !redirect_valid
              && (occ < OW'(PQ_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  assign resp_push = inflight && !redirect_valid;
  assign pop       = id_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & PC_ALIGN;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_STEP;
      end
    end
  end

  if_pq_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (PQ_DEPTH),
    .CW    (CW)
  ) u_pq (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_push),
    .push_data ({inflight_pc, imem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign id_valid = (count != '0);
  assign id_pc    = id_valid ? head[2*XLEN-1:XLEN] : '0;
  assign id_instr = id_valid ? head[XLEN-1:0]
                             : XLEN'(NOP_INSTR);

`ifdef IF_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (issue)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_ready && !id_valid)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage with a ROM[i]=i model.
// Perf counter checks are included when IF_PERF_EN is defined.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en) imem_rdata <= {22'b0, imem_addr};

  if_prefetch_stage #(
    .XLEN     (32),
    .IMEM_AW  (10),
    .RESET_PC (32'h0000_0000),
    .PQ_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] start,
                          input int n);
    exp_t        e;
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.instr = {22'b0, pc[11:2]};
      sb.push_back(e);
      pc = pc + 32'd4;
    end
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic start_run(input logic ready);
    sb.delete();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = ready;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (imem_en !== 1'b0 || id_valid !== 1'b0 ||
        id_pc !== 32'h0 || id_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: en=%b v=%b pc=%h in=%h want 0",
               imem_en, id_valid, id_pc, id_instr);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_en !== 1'b1 || imem_addr !== 10'h0 ||
        id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_c0: en=%b addr=%h v=%b want 1/000/0",
               imem_en, imem_addr, id_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0 || imem_addr !== 10'h1) begin
      miscompares++;
      $display("FAIL reset_c1: v=%b addr=%h want 0/001",
               id_valid, imem_addr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 ||
        id_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_c2: v=%b pc=%h in=%h want 1/0/0",
               id_valid, id_pc, id_instr);
    end
    tick();
  endtask

  task automatic test_stream();
    exp_t e;
    start_run(1'b1);
    push_run(32'h0, 16);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        vectors++;
        if (id_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_bubble: cycle %0d v=%b want 1",
                   c, id_valid);
        end else if (sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if (id_pc !== e.pc || id_instr !== e.instr) begin
            miscompares++;
            $display("FAIL stream: got %h/%h want %h/%h",
                     id_pc, id_instr, e.pc, e.instr);
          end
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL stream_left: %0d left want 0", sb.size());
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   fetches;
    int   got;
    start_run(1'b0);
    fetches = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_en === 1'b1) fetches++;
      if (c >= 2) begin
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
          miscompares++;
          $display("FAIL stall_head: c%0d v=%b pc=%h want 1/0",
                   c, id_valid, id_pc);
        end
      end
      if (c == 11) begin
        vectors++;
        if (imem_en !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_en: en=%b want 0", imem_en);
        end
`ifdef IF_PERF_EN
        vectors++;
        if (perf_fetch_cnt !== 32'd4 ||
            perf_bubble_cnt !== 32'd0) begin
          miscompares++;
          $display("FAIL stall_perf: f=%0d b=%0d want 4/0",
                   perf_fetch_cnt, perf_bubble_cnt);
        end
`endif
      end
      tick();
    end
    vectors++;
    if (fetches != 4) begin
      miscompares++;
      $display("FAIL stall_fetches: %0d want 4", fetches);
    end
    id_ready = 1'b1;
    push_run(32'h0, 8);
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      if (id_valid && id_ready && sb.size() > 0) begin
        e = sb.pop_front();
        got++;
        vectors++;
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          miscompares++;
          $display("FAIL stall_drain: got %h/%h want %h/%h",
                   id_pc, id_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL stall_drain_cnt: %0d want 8", got);
    end
  endtask

  task automatic test_redirect_full();
    exp_t e;
    int   got;
    start_run(1'b0);
    repeat (8) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    id_ready       = 1'b1;
    @(negedge clk);
    vectors++;
    if (imem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rfull_r: en=%b want 0", imem_en);
    end
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0 || imem_en !== 1'b1 ||
        imem_addr !== 10'h040) begin
      miscompares++;
      $display("FAIL rfull_r1: v=%b en=%b addr=%h want 0/1/040",
               id_valid, imem_en, imem_addr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rfull_r2: v=%b want 0", id_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 ||
        id_instr !== 32'h40) begin
      miscompares++;
      $display("FAIL rfull_r3: v=%b pc=%h in=%h want 1/100/40",
               id_valid, id_pc, id_instr);
    end
    tick();
    id_ready = 1'b1;
    push_run(32'h100, 6);
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (id_valid && id_ready && sb.size() > 0) begin
        e = sb.pop_front();
        got++;
        vectors++;
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          miscompares++;
          $display("FAIL rfull_drain: got %h/%h want %h/%h",
                   id_pc, id_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    vectors++;
    if (got != 6) begin
      miscompares++;
      $display("FAIL rfull_drain_cnt: %0d want 6", got);
    end
  endtask

  task automatic test_redirect_inflight();
    exp_t e;
    int   got;
    start_run(1'b1);
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    vectors++;
    if (imem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rinf_r: en=%b want 0", imem_en);
    end
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rinf_r1: v=%b want 0", id_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rinf_r2: v=%b want 0", id_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      miscompares++;
      $display("FAIL rinf_r3: v=%b pc=%h want 1/200",
               id_valid, id_pc);
    end
    tick();
    id_ready = 1'b1;
    push_run(32'h200, 4);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (id_valid && id_ready && sb.size() > 0) begin
        e = sb.pop_front();
        got++;
        vectors++;
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          miscompares++;
          $display("FAIL rinf_drain: got %h/%h want %h/%h",
                   id_pc, id_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL rinf_drain_cnt: %0d want 4", got);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   got;
    start_run(1'b1);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    id_ready       = 1'b0;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_en !== 1'b1 || imem_addr !== 10'h3FF) begin
      miscompares++;
      $display("FAIL wrap_a1: en=%b addr=%h want 1/3ff",
               imem_en, imem_addr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (imem_en !== 1'b1 || imem_addr !== 10'h000) begin
      miscompares++;
      $display("FAIL wrap_a2: en=%b addr=%h want 1/000",
               imem_en, imem_addr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_r3: v=%b pc=%h want 1/fffffffc",
               id_valid, id_pc);
    end
    tick();
    id_ready = 1'b1;
    push_run(32'hFFFF_FFFC, 3);
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (id_valid && id_ready && sb.size() > 0) begin
        e = sb.pop_front();
        got++;
        vectors++;
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          miscompares++;
          $display("FAIL wrap_drain: got %h/%h want %h/%h",
                   id_pc, id_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    vectors++;
    if (got != 3) begin
      miscompares++;
      $display("FAIL wrap_drain_cnt: %0d want 3", got);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   got;
    start_run(1'b0);
    repeat (4) tick();
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    vectors++;
    if (imem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_r: en=%b want 0", imem_en);
    end
    tick();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0 || imem_en !== 1'b1 ||
        imem_addr !== 10'h000) begin
      miscompares++;
      $display("FAIL rmid_c0: v=%b en=%b addr=%h want 0/1/000",
               id_valid, imem_en, imem_addr);
    end
`ifdef IF_PERF_EN
    vectors++;
    if (perf_fetch_cnt !== 32'd0 ||
        perf_bubble_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL rmid_perf: f=%0d b=%0d want 0/0",
               perf_fetch_cnt, perf_bubble_cnt);
    end
`endif
    tick();
    id_ready = 1'b1;
    push_run(32'h0, 3);
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (id_valid && id_ready && sb.size() > 0) begin
        e = sb.pop_front();
        got++;
        vectors++;
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          miscompares++;
          $display("FAIL rmid_drain: got %h/%h want %h/%h",
                   id_pc, id_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    vectors++;
    if (got != 3) begin
      miscompares++;
      $display("FAIL rmid_drain_cnt: %0d want 3", got);
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_inflight();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
